imm_narrow: RTL

- Multicycle inverse of the immediate sign-extender: takes a DATA_BUS_WIDTH value and produces an IMMEDIATE_WIDTH signed immediate.
- Flags whether the value is exactly representable, i.e. whether sign-extending the result reproduces the input.
- Sits between the ALU result path and the instruction-field writer (immediate-encode / compare-and-branch offset path).
- Upper bits are scanned CHUNK_WIDTH bits per cycle to keep the comparator narrow; valid/ready on both sides.

---
 rtl/imm_narrow_pkg.sv | 35 +++
 rtl/imm_narrow_chunk_cmp.sv | 14 +
 rtl/imm_narrow.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/imm_narrow_pkg.sv
// imm_narrow_pkg: shared widths, derived scan geometry, FSM encoding and the
// saturation helper for the immediate narrower.
package imm_narrow_pkg;

  localparam int DATA_BUS_WIDTH  = 64;
  localparam int IMMEDIATE_WIDTH = 11;
  localparam int CHUNK_WIDTH     = 8;

  // Upper bits that must all equal the immediate sign bit.
  localparam int UPPER_WIDTH = DATA_BUS_WIDTH - IMMEDIATE_WIDTH;
  localparam int NUM_CHUNKS  = (UPPER_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int IDX_WIDTH   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  // The chunk table is padded to a power-of-two count so any index value
  // (including the look-ahead past the last chunk) selects a defined slice.
  localparam int NUM_SLOTS   = 1 << IDX_WIDTH;
  localparam int SCAN_WIDTH  = NUM_SLOTS * CHUNK_WIDTH;

  typedef enum logic [1:0] {
    IMMN_IDLE = 2'd0,
    IMMN_SCAN = 2'd1,
    IMMN_DONE = 2'd2
  } immn_state_e;

  // Most-positive / most-negative immediate selected by the source sign.
  function automatic logic [IMMEDIATE_WIDTH-1:0] sat_imm(input logic sign);
    logic [IMMEDIATE_WIDTH-1:0] res;
    if (sign) begin
      res = {1'b1, {(IMMEDIATE_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b0, {(IMMEDIATE_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/imm_narrow_chunk_cmp.sv
// imm_chunk_cmp: flags any in-range bit of one upper-bit chunk that differs
// from the immediate sign bit. Bits with mask=0 lie beyond the data word.
module imm_chunk_cmp
  import imm_narrow_pkg::*;
(
  input  logic [CHUNK_WIDTH-1:0] slice,
  input  logic [CHUNK_WIDTH-1:0] mask,
  input  logic                   sign,
  output logic                   mismatch
);

  assign mismatch = |((slice ^ {CHUNK_WIDTH{sign}}) & mask);

endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: multicycle signed narrowing of a DATA_BUS_WIDTH value to an
// IMMEDIATE_WIDTH immediate with a representability (overflow) flag.
// The upper bits are checked one CHUNK_WIDTH slice per cycle; the slice is
// registered ahead of the comparator, so one fetch cycle precedes the
// NUM_CHUNKS compare cycles.
// Build option: define IMM_NARROW_SATURATE_EN to clamp out_imm on overflow;
// otherwise out_imm is always the truncated low bits.
module imm_narrow
  import imm_narrow_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_BUS_WIDTH-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IMMEDIATE_WIDTH-1:0] out_imm,
  output logic                       out_ovf
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHUNKS - 1);

  immn_state_e                     state_r;
  logic [DATA_BUS_WIDTH-1:0]       data_r;
  logic [IDX_WIDTH-1:0]            idx_r;
  logic                            mismatch_r;
  logic [CHUNK_WIDTH-1:0]          slice_r;
  logic [CHUNK_WIDTH-1:0]          mask_r;
  logic                            slice_vld_r;
  logic                            in_ready_r;
  logic                            out_valid_r;
  logic [IMMEDIATE_WIDTH-1:0]      out_imm_r;
  logic                            out_ovf_r;

  logic [SCAN_WIDTH-1:0]                   upper_flat_s;
  logic [SCAN_WIDTH-1:0]                   inrange_flat_s;
  logic [NUM_SLOTS-1:0][CHUNK_WIDTH-1:0]   upper_s;
  logic [NUM_SLOTS-1:0][CHUNK_WIDTH-1:0]   inrange_s;
  logic [IDX_WIDTH-1:0]                    fetch_idx_s;
  logic [CHUNK_WIDTH-1:0]                  fetch_slice_s;
  logic [CHUNK_WIDTH-1:0]                  fetch_mask_s;
  logic                                    cmp_s;
  logic                                    mis_next_s;
  logic [IMMEDIATE_WIDTH-1:0]              result_imm_s;

  // Zero-extend the upper bits into the chunk table and mark which bits exist.
  always_comb begin
    upper_flat_s   = '0;
    inrange_flat_s = '0;
    upper_flat_s[UPPER_WIDTH-1:0]   = data_r[DATA_BUS_WIDTH-1:IMMEDIATE_WIDTH];
    inrange_flat_s[UPPER_WIDTH-1:0] = {UPPER_WIDTH{1'b1}};
    upper_s   = upper_flat_s;
    inrange_s = inrange_flat_s;
  end

  // Pick the chunk to load next: chunk 0 on the fetch cycle, else idx+1.
  always_comb begin
    if (slice_vld_r) begin
      fetch_idx_s = idx_r + 1'b1;
    end else begin
      fetch_idx_s = idx_r;
    end
    fetch_slice_s = upper_s[fetch_idx_s];
    fetch_mask_s  = inrange_s[fetch_idx_s];
  end

  imm_chunk_cmp u_cmp (
    .slice    (slice_r),
    .mask     (mask_r),
    .sign     (data_r[IMMEDIATE_WIDTH-1]),
    .mismatch (cmp_s)
  );

  // Fold the current chunk into the sticky flag and form the final immediate.
  always_comb begin
    mis_next_s = mismatch_r | cmp_s;
`ifdef IMM_NARROW_SATURATE_EN
    if (mis_next_s) begin
      result_imm_s = sat_imm(data_r[DATA_BUS_WIDTH-1]);
    end else begin
      result_imm_s = data_r[IMMEDIATE_WIDTH-1:0];
    end
`else
    result_imm_s = data_r[IMMEDIATE_WIDTH-1:0];
`endif
  end

  // Control FSM: capture in IDLE, chunk scan in SCAN, hold result in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IMMN_IDLE;
      data_r      <= '0;
      idx_r       <= '0;
      mismatch_r  <= 1'b0;
      slice_r     <= '0;
      mask_r      <= '0;
      slice_vld_r <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_imm_r   <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IMMN_IDLE: begin
          if (in_valid && in_ready_r) begin
            data_r      <= in_data;
            idx_r       <= '0;
            mismatch_r  <= 1'b0;
            slice_vld_r <= 1'b0;
            in_ready_r  <= 1'b0;
            state_r     <= IMMN_SCAN;
          end
        end
        IMMN_SCAN: begin
          slice_r <= fetch_slice_s;
          mask_r  <= fetch_mask_s;
          if (!slice_vld_r) begin
            slice_vld_r <= 1'b1;
          end else begin
            mismatch_r <= mis_next_s;
            if (idx_r == LAST_IDX) begin
              slice_vld_r <= 1'b0;
              out_valid_r <= 1'b1;
              out_ovf_r   <= mis_next_s;
              out_imm_r   <= result_imm_s;
              state_r     <= IMMN_DONE;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
        end
        IMMN_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IMMN_IDLE;
          end
        end
        default: begin
          slice_vld_r <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IMMN_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_imm   = out_imm_r;
  assign out_ovf   = out_ovf_r;

endmodule
